data_ram_mmio: RTL

//  Parametrised data memory for the Harvard MIPS datapath, generalising the 32-bit/2K-word RAM with one 8-bit output port.

---
 rtl/data_ram_mmio_pkg.sv | 9 +
 rtl/data_ram_mmio_ram_bank.sv | 23 ++
 rtl/data_ram_mmio.sv | 87 ++++++++
 3 files changed

// File: rtl/data_ram_mmio_pkg.sv
// data_ram_mmio_pkg: shared widths and address-map helper for the MEM-stage data RAM
package data_ram_mmio_pkg;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_ADDR_W = 11;
   localparam int BYTES = MEM_DATA_W / 8;
   function automatic int mmio_base(input int aw, input int np);
      return (1 << aw) - np;
   endfunction
endpackage

// File: rtl/data_ram_mmio_ram_bank.sv
// data_ram_mmio_ram_bank: unreset storage array with byte-enable write and registered read
module data_ram_mmio_ram_bank #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11,
   parameter int DEPTH  = 2047
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [DATA_W/8-1:0]   be_i,
   output logic [DATA_W-1:0]     rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   // read returns the pre-write word; the top forwards enabled bytes itself
   always_ff @(posedge clk_i) begin
      if (we_i)
         for (int b = 0; b < DATA_W / 8; b++)
            if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      if (re_i) rdata_o <= mem_q[addr_i];
   end
endmodule

// File: rtl/data_ram_mmio.sv
// data_ram_mmio: data RAM with byte enables, registered read, forwarding and MMIO output ports
module data_ram_mmio
   import data_ram_mmio_pkg::*;
#(
   parameter int DATA_W    = MEM_DATA_W,
   parameter int ADDR_W    = MEM_ADDR_W,
   parameter int NUM_PORTS = 1,
   parameter int PORT_W    = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [ADDR_W-1:0]           addr_i,
   input  logic [DATA_W-1:0]           data_in_i,
   input  logic                        wen_i,
   input  logic [DATA_W/8-1:0]         be_i,
   input  logic                        ren_i,
   output logic [DATA_W-1:0]           rd_data_o,
   output logic                        rd_valid_o,
   output logic [NUM_PORTS*PORT_W-1:0] port_out_o,
   output logic                        err_o
);
   localparam int NB = DATA_W / 8;
   localparam int DEPTH = mmio_base(ADDR_W, NUM_PORTS);
   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(DEPTH);
   logic                                is_port, pidx_ok;
   logic [ADDR_W-1:0]                   pidx;
   logic [NUM_PORTS-1:0][PORT_W-1:0]    port_q, port_d;
   logic [PORT_W-1:0]                   port_rd;
   logic [DATA_W-1:0]                   bank_q, fdata_q, fdata_d;
   logic [NB-1:0]                       fmask_q, fmask_d;
   logic                                have_q, have_d, valid_q, err_q, err_d;
   data_ram_mmio_ram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_bank (
      .clk_i   (clk_i),
      .we_i    (wen_i & ~is_port),
      .re_i    (ren_i & ~is_port),
      .addr_i  (addr_i),
      .wdata_i (data_in_i),
      .be_i    (be_i),
      .rdata_o (bank_q)
   );
   always_comb begin
      is_port = addr_i >= BASE_A;
      pidx    = addr_i - BASE_A;
      pidx_ok = pidx < ADDR_W'(NUM_PORTS);
   end
   // port_d already carries a same-cycle write, so port reads are write-first
   always_comb begin
      port_d  = port_q;
      port_rd = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (wen_i && is_port && be_i[0] && pidx == ADDR_W'(k)) port_d[k] = data_in_i[PORT_W-1:0];
         if (pidx == ADDR_W'(k)) port_rd = port_d[k];
      end
   end
   always_comb begin
      have_d  = have_q | ren_i;
      fmask_d = ren_i ? (is_port ? {NB{1'b1}} : (wen_i ? be_i : {NB{1'b0}})) : fmask_q;
      fdata_d = ren_i ? (is_port ? DATA_W'(port_rd) : data_in_i) : fdata_q;
      err_d   = err_q | ((wen_i | ren_i) & is_port & ~pidx_ok);
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         port_q  <= '0;
         have_q  <= 1'b0;
         valid_q <= 1'b0;
         fmask_q <= '0;
         fdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         port_q  <= port_d;
         have_q  <= have_d;
         valid_q <= ren_i;
         fmask_q <= fmask_d;
         fdata_q <= fdata_d;
         err_q   <= err_d;
      end
   end
   // have_q masks the unreset bank output until the first read after reset
   always_comb begin
      rd_data_o = '0;
      for (int b = 0; b < NB; b++)
         rd_data_o[8*b +: 8] = have_q ? (fmask_q[b] ? fdata_q[8*b +: 8] : bank_q[8*b +: 8]) : 8'h00;
   end
   assign rd_valid_o = valid_q;
   assign port_out_o = port_q;
   assign err_o      = err_q;
endmodule
